// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: default frame geometry,
// sequencer state encoding and the bit-reversal helper used on unload.
package fft_pkg;

  localparam int FFT_NUMSTAGES  = 5;
  localparam int FFT_NUMSAMPLES = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_UNLOAD = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RUN    = ST_RUN,
    GAP    = ST_GAP,
    UNLOAD = ST_UNLOAD,
    DONE   = ST_DONE
  } seq_state_e;

  function automatic logic [FFT_NUMSTAGES-1:0] bitrev(input logic [FFT_NUMSTAGES-1:0] v);
    logic [FFT_NUMSTAGES-1:0] r;
    r = '0;
    for (int i = 0; i < FFT_NUMSTAGES; i++) begin
      r[i] = v[FFT_NUMSTAGES-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_xfer_counter.sv
// Handshake transfer counter: clears on request, advances once per accepted
// transfer and flags the final index of the frame.
module fft_xfer_counter #(
  parameter int W    = 5,
  parameter int LAST = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == W'(LAST));

endmodule

// File: rtl/fft_sequencer.sv
// FFT frame sequencer: loads a frame, steps fft_stage_control through every
// stage, then unloads. Build option FFT_BITREV_UNLOAD_EN bit-reverses out_addr.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES  = FFT_NUMSTAGES,
  parameter int NUMSAMPLES = FFT_NUMSAMPLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUMSTAGES-1:0] in_addr,
  output logic                 ld_data,
  output logic                 en,
  output logic [2:0]           stage_num,
  input  logic                 stage_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUMSTAGES-1:0] out_addr,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] LAST_STAGE = 3'(NUMSTAGES - 1);

  seq_state_e           state;
  seq_state_e           state_nxt;
  logic                 ld_xfer;
  logic                 ul_xfer;
  logic                 stage_hit;
  logic                 ld_last;
  logic                 ul_last;
  logic                 cnt_clr;
  logic [NUMSTAGES-1:0] ld_cnt;
  logic [NUMSTAGES-1:0] ul_cnt;

  // Handshake strobes are decoded from the state register only
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign ld_xfer   = in_valid & in_ready;
  assign ul_xfer   = out_valid & out_ready;
  assign stage_hit = (state == RUN) & en & stage_done;
  assign cnt_clr   = (state == IDLE);

  fft_xfer_counter #(
    .W    (NUMSTAGES),
    .LAST (NUMSAMPLES - 1)
  ) u_ld_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (ld_xfer),
    .cnt  (ld_cnt),
    .last (ld_last)
  );

  fft_xfer_counter #(
    .W    (NUMSTAGES),
    .LAST (NUMSAMPLES - 1)
  ) u_ul_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (ul_xfer),
    .cnt  (ul_cnt),
    .last (ul_last)
  );

  assign in_addr = ld_cnt;

`ifdef FFT_BITREV_UNLOAD_EN
  assign out_addr = bitrev(ul_cnt);
`else
  assign out_addr = ul_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (ld_xfer && ld_last) state_nxt = RUN;
      RUN: begin
        if (stage_hit) begin
          state_nxt = (stage_num == LAST_STAGE) ? UNLOAD : GAP;
        end
      end
      GAP:     state_nxt = RUN;
      UNLOAD:  if (ul_xfer && ul_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_data    <= 1'b0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      stage_num  <= 3'd0;
    end else begin
      ld_data    <= (state_nxt == RUN) || (state_nxt == GAP);
      en         <= (state_nxt == RUN);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
      if (state == IDLE || state == DONE) begin
        stage_num <= 3'd0;
      end else if (stage_hit && stage_num != LAST_STAGE) begin
        stage_num <= stage_num + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: frame-level reference model plus
// hand-computed sequence checks on load, stage stepping, unload and reset.
module tb_fft_sequencer;

  localparam int NS    = 5;
  localparam int NSAMP = 32;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_GAP = 3, P_UNL = 4, P_DONE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [NS-1:0] in_addr;
  logic          ld_data;
  logic          en;
  logic [2:0]    stage_num;
  logic          stage_done;
  logic          out_valid;
  logic          out_ready;
  logic [NS-1:0] out_addr;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  fft_sequencer #(.NUMSTAGES(NS), .NUMSAMPLES(NSAMP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .ld_data    (ld_data),
    .en         (en),
    .stage_num  (stage_num),
    .stage_done (stage_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int f_rev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < NS; i++) if (v[i]) r = r | (1 << (NS - 1 - i));
    return r;
  endfunction

  function automatic int exp_oaddr(input int idx);
`ifdef FFT_BITREV_UNLOAD_EN
    return f_rev(idx);
`else
    return idx;
`endif
  endfunction

  // Frame-level reference model: phase plus transfer/stage tallies
  int m_ph = P_IDLE, m_nld = 0, m_nout = 0, m_stage = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= P_IDLE; m_nld <= 0; m_nout <= 0; m_stage <= 0;
    end else begin
      case (m_ph)
        P_IDLE: if (start) m_ph <= P_LOAD;
        P_LOAD: if (in_valid) begin
          if (m_nld == NSAMP - 1) begin m_nld <= 0; m_ph <= P_RUN; end
          else m_nld <= m_nld + 1;
        end
        P_RUN: if (stage_done) begin
          if (m_stage == NS - 1) m_ph <= P_UNL;
          else begin m_stage <= m_stage + 1; m_ph <= P_GAP; end
        end
        P_GAP: m_ph <= P_RUN;
        P_UNL: if (out_ready) begin
          if (m_nout == NSAMP - 1) begin m_nout <= 0; m_ph <= P_DONE; end
          else m_nout <= m_nout + 1;
        end
        default: begin m_ph <= P_IDLE; m_stage <= 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_ph != P_IDLE);
      chk("in_ready", in_ready, m_ph == P_LOAD);
      chk("ld_data", ld_data, (m_ph == P_RUN) || (m_ph == P_GAP));
      chk("en", en, m_ph == P_RUN);
      chk("out_valid", out_valid, m_ph == P_UNL);
      chk("frame_done", frame_done, m_ph == P_DONE);
      chk("stage_num", stage_num, m_stage);
      if (in_ready) chk("in_addr", in_addr, m_nld);
      if (out_valid) chk("out_addr", out_addr, exp_oaddr(m_nout));
    end
  end

  // Per-frame event records, cleared when a frame is requested from IDLE
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_in[$], q_st[$], q_gap[$], q_oa[$];
  int inrdy_cnt = 0, fd_cnt = 0, gap_run = 0;
  int x31_cyc = -1, ld_rise_cyc = -1, last_out_cyc = -1, fd_cyc = -1;
  logic ld_prev = 1'b0, en_prev = 1'b0;

  always @(negedge clk) begin
    if (start && !busy && !rst) begin
      q_in.delete(); q_st.delete(); q_gap.delete(); q_oa.delete();
      inrdy_cnt <= 0; fd_cnt <= 0; gap_run <= 0;
    end else begin
      if (in_ready) inrdy_cnt <= inrdy_cnt + 1;
      if (in_ready && in_valid) begin
        q_in.push_back(int'(in_addr));
        if (in_addr == NS'(NSAMP - 1)) x31_cyc <= cyc;
      end
      if (ld_data && !ld_prev) ld_rise_cyc <= cyc;
      if (en && !en_prev) begin
        q_st.push_back(int'(stage_num));
        if (gap_run > 0) q_gap.push_back(gap_run);
        gap_run <= 0;
      end else if (ld_data && !en) begin
        gap_run <= gap_run + 1;
      end
      if (out_valid && out_ready) begin
        q_oa.push_back(int'(out_addr));
        last_out_cyc <= cyc;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc <= cyc;
      end
    end
    ld_prev <= ld_data;
    en_prev <= en;
  end

  // Stimulus responders: stage model, input source, output sink
  bit force_load = 0, force_gap = 0, tog = 0, iv_on = 0;
  int iv_mode = 0;

  initial begin
    int ecnt, uidx, tick;
    bit en_q;
    ecnt = 0; uidx = 0; tick = 0; en_q = 0;
    stage_done = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (en && !en_q) ecnt = 0;
      else if (en) ecnt++;
      en_q = en;
      stage_done = (en && ecnt == 8) || (force_load && in_ready) || (force_gap && ld_data && !en);
      in_valid = iv_on && (iv_mode == 0 || (tick % 3) != 0);
      tick++;
      if (!tog) out_ready = 1'b1;
      else if (out_valid) begin out_ready = (uidx % 2 == 0); uidx++; end
      else begin out_ready = 1'b0; uidx = 0; end
    end
  end

  task automatic wait_fd(input string nm);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    chk(nm, k < 2000, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_ld_data"}, ld_data, 0);
    chk({nm, "_en"}, en, 0);
    chk({nm, "_stage_num"}, stage_num, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_in_addr"}, in_addr, 0);
    chk({nm, "_out_addr"}, out_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp4[4];
    int k;
`ifdef FFT_BITREV_UNLOAD_EN
    exp4 = '{0, 16, 8, 24};
`else
    exp4 = '{0, 1, 2, 3};
`endif
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1 rst = 1'b0;
    chk_en = 1;

    // Frame A: continuous input, toggled output, stage_done forced in LOAD and GAP
    iv_on = 1; iv_mode = 0; tog = 1; force_load = 1; force_gap = 1;
    pulse_start();
    wait_fd("A_frame_timeout");
    repeat (3) @(negedge clk);
    chk("A_in_ready_cycles", inrdy_cnt, 32);
    chk("A_in_count", q_in.size(), 32);
    for (int i = 0; i < q_in.size(); i++) chk("A_in_addr_seq", q_in[i], i);
    chk("A_ld_rise", ld_rise_cyc - x31_cyc, 1);
    chk("A_stage_count", q_st.size(), 5);
    for (int i = 0; i < q_st.size(); i++) chk("A_stage_seq", q_st[i], i);
    chk("A_gap_count", q_gap.size(), 4);
    foreach (q_gap[i]) chk("A_gap_len", q_gap[i], 1);
    chk("A_out_count", q_oa.size(), 32);
    for (int i = 0; i < 4 && i < q_oa.size(); i++) chk("A_out_addr_seq", q_oa[i], exp4[i]);
    chk("A_frame_done_pulses", fd_cnt, 1);
    chk("A_frame_done_delay", fd_cyc - last_out_cyc, 1);
    force_load = 0; force_gap = 0;

    // Frame B: gappy input, steady output, start asserted during UNLOAD
    iv_mode = 1; tog = 0;
    pulse_start();
    k = 0;
    while (out_valid !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    chk("B_unload_timeout", k < 2000, 1);
    @(posedge clk); #1 start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_fd("B_frame_timeout");
    repeat (3) @(negedge clk);
    chk("B_idle_after", busy, 0);
    chk("B_in_count", q_in.size(), 32);
    chk("B_out_count", q_oa.size(), 32);
    for (int i = 0; i < 4 && i < q_oa.size(); i++) chk("B_out_addr_seq", q_oa[i], exp4[i]);
    chk("B_frame_done_pulses", fd_cnt, 1);

    // Frame C: asynchronous reset in the middle of stage 2
    iv_mode = 0;
    pulse_start();
    k = 0;
    while (!(stage_num === 3'd2 && en === 1'b1) && k < 2000) begin @(negedge clk); k++; end
    chk("C_stage2_timeout", k < 2000, 1);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun");
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("C_stay_idle", busy, 0);

    // Frame D: normal frame after the abort
    pulse_start();
    wait_fd("D_frame_timeout");
    repeat (2) @(negedge clk);
    chk("D_out_count", q_oa.size(), 32);
    chk("D_frame_done_pulses", fd_cnt, 1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Initiator side of the stage-control interface: drives ld_data, en and stage_num into fft_stage_control and consumes its stage_done.
- Sequences one complete FFT frame: load NUMSAMPLES samples through a valid/ready port, run stages 0..NUMSTAGES-1, then unload NUMSAMPLES results.
- Sits in the FFT top level between the sample I/O ports and fft_stage_control / butterfly datapath.

Parameters:
- NUMSTAGES, 5, number of radix-2 stages; log2 of the frame length.
- NUMSAMPLES, 32, frame length; must equal 2**NUMSTAGES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- in_valid  in  1  input sample present.
- in_ready  out  1  sequencer accepts an input sample this cycle.
- in_addr  out  NUMSTAGES  sample-memory write index for the accepted sample.
- ld_data  out  1  high = memory loaded, stage control owns memory.
- en  out  1  stage enable to fft_stage_control.
- stage_num  out  3  current stage index.
- stage_done  in  1  stage complete, from fft_stage_control.
- out_valid  out  1  result index valid.
- out_ready  in  1  downstream accepts a result.
- out_addr  out  NUMSTAGES  sample-memory read index of the current result.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last result transfers.

Behaviour:
- Reset values (async, immediate): state=IDLE; in_ready=0, ld_data=0, en=0, stage_num=0, out_valid=0, busy=0, frame_done=0; load/unload counters=0.
- States: IDLE, LOAD, RUN, GAP, UNLOAD, DONE.
- IDLE: start=1 -> LOAD next cycle. Counters and stage_num cleared.
- LOAD: in_ready=1, in_addr=load counter. A transfer happens on in_valid&&in_ready; the counter increments on each transfer. Transfer at count NUMSAMPLES-1 -> RUN. The counter wraps to 0. in_ready is low the following cycle.
- RUN: ld_data=1, en=1. stage_done&&en:
  - stage_num<NUMSTAGES-1 -> stage_num+1, en=0 next cycle (GAP).
  - stage_num==NUMSTAGES-1 -> UNLOAD, en=0; stage_num holds until IDLE.
- GAP: exactly one cycle with en=0, then RUN. This matches the stage-control requirement that en drop for one cycle between stages.
- stage_done while en=0 (GAP, LOAD, UNLOAD) is ignored.
- UNLOAD: ld_data=0, out_valid=1, out_addr=unload counter (see Optional Feature). Transfer on out_valid&&out_ready. Counter increments per transfer. Last transfer -> DONE.
- DONE: frame_done=1 for one cycle, busy=1, then IDLE.
- start while busy is ignored; no queuing.
- Back-pressure: in_valid=0 or out_ready=0 stalls indefinitely; no timeout.
- Latency with no stalls: 1 (IDLE->LOAD) + NUMSAMPLES + sum of stage lengths + (NUMSTAGES-1) gap cycles + NUMSAMPLES + 1 (DONE).
- All outputs are registered, except in_ready and out_valid, which are decoded directly from the state register (no combinational path from inputs).
- rst asserted mid-frame aborts immediately to IDLE. Partial memory contents are don't-care.

Optional Feature:
- Macro: FFT_BITREV_UNLOAD_EN.
- Defined: out_addr = bit-reversed unload counter (NUMSTAGES bits), so results leave in natural frequency order.
- Undefined: out_addr = unload counter unchanged; results leave in memory order.

Decomposition:
- Shared package fft_pkg:
  - state encoding localparams (IDLE=0 .. DONE=5, 3 bits).
  - NUMSTAGES/NUMSAMPLES defaults.
  - a bitrev function of width NUMSTAGES.
- One natural sub-module: fft_xfer_counter. It is a NUMSTAGES-bit counter with clear, increment-on-handshake and last flag, instantiated twice (load and unload).

Test Plan:
- Reset mid-RUN (stage_num=2, en=1) -> next sample all outputs at reset values, state IDLE, busy=0.
- start=1, in_valid held 1 -> in_ready high exactly 32 cycles; in_addr 0..31; ld_data rises the cycle after the transfer at in_addr=31.
- Stage model returns stage_done 8 cycles after en rises -> stage_num steps 0,1,2,3,4, en low exactly one cycle between stages; no increment past 4.
- stage_done forced high during GAP and LOAD -> stage_num unchanged.
- out_ready toggling 1,0,1,0 -> 32 transfers, out_addr increments only on transfer; frame_done pulses once, one cycle after transfer 32.
- With FFT_BITREV_UNLOAD_EN -> out_addr sequence 0,16,8,24,4,...; without it -> 0,1,2,3,...; start asserted during UNLOAD is ignored in both builds.
